// File: rtl/spike_rate_encoder.sv
// spike_rate_encoder: loads a frame of per-channel intensities, then emits
// WINDOW timesteps of sigma-delta rate-coded spikes (carry-out of an
// accumulator that adds the channel intensity every step).
module spike_rate_encoder #(
  parameter int unsigned NUM_CHANNELS = 10,
  parameter int unsigned WIDTH_P      = 8,
  parameter int unsigned WINDOW       = 16,
  localparam int unsigned STEP_W      = (WINDOW > 1) ? $clog2(WINDOW) : 1
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    valid_i,
  output logic                    ready_o,
  input  logic [WIDTH_P-1:0]      data_i,
  output logic [NUM_CHANNELS-1:0] spike_o,
  output logic                    spike_valid_o,
  output logic [STEP_W-1:0]       step_o,
  output logic                    done_o
);

  localparam int unsigned PTR_W = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;

  typedef enum logic {
    LOAD = 1'b0,
    RUN  = 1'b1
  } state_e;

  state_e                   state_q, state_d;
  logic [PTR_W-1:0]         wr_ptr_q, wr_ptr_d;
  logic [STEP_W-1:0]        cnt_q, cnt_d;
  logic [WIDTH_P-1:0]       int_q [NUM_CHANNELS];
  logic [WIDTH_P-1:0]       int_d [NUM_CHANNELS];
  logic [WIDTH_P-1:0]       acc_q [NUM_CHANNELS];
  logic [WIDTH_P-1:0]       acc_d [NUM_CHANNELS];
  logic [WIDTH_P:0]         sum_c [NUM_CHANNELS];
  logic [NUM_CHANNELS-1:0]  spike_q, spike_d;
  logic                     spike_valid_q, spike_valid_d;
  logic [STEP_W-1:0]        step_q, step_d;
  logic                     done_q, done_d;

  assign ready_o       = (state_q == LOAD);
  assign spike_o       = spike_q;
  assign spike_valid_o = spike_valid_q;
  assign step_o        = step_q;
  assign done_o        = done_q;

  // Per-channel accumulator sum; the top bit is the spike for this step.
  always_comb begin
    for (int n = 0; n < NUM_CHANNELS; n++) begin
      sum_c[n] = {1'b0, acc_q[n]} + {1'b0, int_q[n]};
    end
  end

  // Next-state logic: beat capture in LOAD, accumulate and emit in RUN.
  always_comb begin
    state_d       = state_q;
    wr_ptr_d      = wr_ptr_q;
    cnt_d         = cnt_q;
    int_d         = int_q;
    acc_d         = acc_q;
    spike_d       = '0;
    spike_valid_d = 1'b0;
    step_d        = '0;
    done_d        = 1'b0;

    case (state_q)
      LOAD: begin
        if (valid_i) begin
          int_d[wr_ptr_q] = data_i;
          if (wr_ptr_q == PTR_W'(NUM_CHANNELS - 1)) begin
            wr_ptr_d = '0;
            cnt_d    = '0;
            for (int n = 0; n < NUM_CHANNELS; n++) begin
              acc_d[n] = '0;
            end
            state_d  = RUN;
          end else begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
          end
        end
      end
      RUN: begin
        for (int n = 0; n < NUM_CHANNELS; n++) begin
          spike_d[n] = sum_c[n][WIDTH_P];
          acc_d[n]   = sum_c[n][WIDTH_P-1:0];
        end
        spike_valid_d = 1'b1;
        step_d        = cnt_q;
        done_d        = (cnt_q == STEP_W'(WINDOW - 1));
        if (done_d) begin
          cnt_d   = '0;
          state_d = LOAD;
        end else begin
          cnt_d   = cnt_q + STEP_W'(1);
        end
      end
      default: state_d = LOAD;
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q       <= LOAD;
      wr_ptr_q      <= '0;
      cnt_q         <= '0;
      spike_q       <= '0;
      spike_valid_q <= 1'b0;
      step_q        <= '0;
      done_q        <= 1'b0;
      for (int n = 0; n < NUM_CHANNELS; n++) begin
        int_q[n] <= '0;
        acc_q[n] <= '0;
      end
    end else begin
      state_q       <= state_d;
      wr_ptr_q      <= wr_ptr_d;
      cnt_q         <= cnt_d;
      spike_q       <= spike_d;
      spike_valid_q <= spike_valid_d;
      step_q        <= step_d;
      done_q        <= done_d;
      for (int n = 0; n < NUM_CHANNELS; n++) begin
        int_q[n] <= int_d[n];
        acc_q[n] <= acc_d[n];
      end
    end
  end

endmodule
